fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage between instruction cache and decode. Owns the PC and issues sequential
//  requests to the I-cache (ICacheFetchIf.fetch side). Buffers in-order responses in a small queue
//  and presents one instruction per cycle to decode (FetchDecIf.fetch side).
//  Redirects the PC on decode jump/branch or backend flush, discarding stale in-flight responses.
// PARAMETERS
//  ADDR      `AddrWidth  address / PC width
//  INST      `InstWidth  instruction width
//  RESET_PC  0           PC loaded at reset
//  QDEPTH    4           instruction queue entries (power of 2, >=2)
//  MAX_OUT   4           max outstanding I-cache requests
//  PC_STEP   4           sequential PC increment (bytes)
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous reset, active-high
//  fetch_e_     out  1     request valid to I-cache, active-low
//  fetch_pc     out  ADDR  request address
//  ic_e_        in   1     response valid from I-cache, active-low
//  ic_pc        in   ADDR  address of returned instruction
//  ic_inst      in   INST  returned instruction
//  inst_e_      out  1     instruction valid to decode, active-low
//  inst_pc      out  ADDR  PC of presented instruction
//  inst         out  INST  presented instruction
//  dec_jump_    in   1     decode jump redirect, active-low
//  dec_branch_  in   1     decode taken-branch redirect, active-low
//  dec_target   in   ADDR  redirect target for jump/branch
//  stall        in   1     backend stall; hold presented instruction, no pop
//  flush_       in   1     backend flush (mispredict/exception), active-low
//  flush_pc     in   ADDR  flush restart address
// BEHAVIOUR
//  Reset (sync, active-high): pc=RESET_PC; queue empty; outstanding=0; discard=0;
//   fetch_e_=1, inst_e_=1, fetch_pc=RESET_PC, inst_pc=0, inst=0.
//  I-cache contract: every cycle with fetch_e_=0 is accepted; responses return in order, latency >=1.
//  Issue: fetch_e_=0 iff no redirect this cycle, outstanding<MAX_OUT, and
//   (queue count + outstanding) < QDEPTH (credit rule: a response always has a slot).
//   fetch_pc = pc (combinational from register). On issue: pc += PC_STEP (wraps mod 2^ADDR).
//  Response: ic_e_=0 with discard>0 -> dropped, discard--. Otherwise pushed {ic_pc, ic_inst}.
//   outstanding -= 1 per response; +1 per issue; both in one cycle -> unchanged.
//  Output: inst_e_=0 iff queue non-empty and stall=0; inst_pc/inst = queue head (combinational).
//   Pop when inst_e_=0. Response arriving to an empty queue is visible next cycle (1-cycle min latency).
//   Simultaneous push and pop when full is impossible by the credit rule; push+pop when non-full both occur.
//  Redirect priority: flush_=0 > dec_jump_=0 > dec_branch_=0. Target = flush_pc or dec_target.
//   Redirect cycle: no issue, no pop (inst_e_ forced 1), response dropped; queue cleared;
//   pc <= target; discard <= outstanding - (response this cycle ? 1 : 0), outstanding unchanged otherwise.
//   Issue from target begins the next cycle. Back-to-back redirects: last one wins; discard recomputed.
//  Decode asserting a redirect must not consume the instruction shown in that same cycle.
//  Widths: counters sized $clog2(QDEPTH)+1 and $clog2(MAX_OUT)+1; never under/overflow (assertions).
// STRUCTURE
//  fetch_pkg: FetchQueueEntry_t {pc, inst}, PC_STEP default, redirect-source enum.
//  Sub-module fetch_queue: synchronous FIFO (QDEPTH x entry), push/pop/clear, count, empty/full.
//  fetch_unit holds PC, outstanding/discard counters, issue and redirect logic.
// TESTING
//  Reset, I-cache latency 1, no stall -> fetch_pc 0,4,8,..; inst_e_=0 from cycle 3, inst_pc 0,4,8 in order.
//  stall=1 for 10 cycles -> issue stops at queue count + outstanding = 4; head held; resumes, no loss/dup.
//  I-cache latency 3, dec_jump_=0 target 0x100 with 3 outstanding -> 3 responses dropped, next inst_pc=0x100.
//  flush_=0 (0x200) and dec_branch_=0 (0x300) same cycle -> pc=0x200; queue empty next cycle.
//  Response and redirect same cycle, outstanding=2 -> discard=1; first post-redirect inst_pc = target.
//  reset asserted mid-stream with 2 outstanding -> all outputs at reset values next cycle; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int PC_STEP_DEF = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_queue_entry_t;
  typedef enum logic [1:0] {REDIR_NONE, REDIR_FLUSH, REDIR_JUMP, REDIR_BRANCH} redirect_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous fifo of fetched {pc, inst} entries with clear
module fetch_queue #(
  parameter int W = 64,
  parameter int DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign dout  = mem[rd_ptr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc owner issuing in-order i-cache requests and feeding decode from a credit-checked queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR = ADDR_W,
  parameter int INST = INST_W,
  parameter logic [ADDR-1:0] RESET_PC = '0,
  parameter int QDEPTH = 4,
  parameter int MAX_OUT = 4,
  parameter int PC_STEP = PC_STEP_DEF
)(
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_e_,
  output logic [ADDR-1:0] fetch_pc,
  input  logic            ic_e_,
  input  logic [ADDR-1:0] ic_pc,
  input  logic [INST-1:0] ic_inst,
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic [INST-1:0] inst,
  input  logic            dec_jump_,
  input  logic            dec_branch_,
  input  logic [ADDR-1:0] dec_target,
  input  logic            stall,
  input  logic            flush_,
  input  logic [ADDR-1:0] flush_pc
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int SW = (CW > OW ? CW : OW) + 1;
  logic [ADDR-1:0] pc, target;
  logic [OW-1:0] outstanding, discard;
  logic [CW-1:0] count;
  logic [ADDR+INST-1:0] head;
  logic empty, full, redir, resp, issue, push, pop;
  redirect_e src;
  always_comb begin
    src = !flush_ ? REDIR_FLUSH : !dec_jump_ ? REDIR_JUMP : !dec_branch_ ? REDIR_BRANCH : REDIR_NONE;
    redir = src != REDIR_NONE;
    target = src == REDIR_FLUSH ? flush_pc : dec_target;
    resp = !ic_e_;
    // credit rule: every outstanding request already owns a queue slot
    issue = !reset && !redir && outstanding < OW'(MAX_OUT) &&
            SW'(count) + SW'(outstanding) < SW'(QDEPTH);
    push = resp && !redir && discard == '0;
    pop = !reset && !redir && !empty && !stall;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      pc          <= redir ? target : issue ? pc + ADDR'(PC_STEP) : pc;
      outstanding <= outstanding + OW'(issue) - OW'(resp);
      discard     <= redir ? outstanding - OW'(resp) : discard - OW'(resp && discard != '0);
    end
  end
  fetch_queue #(.W(ADDR + INST), .DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redir),
    .din   ({ic_pc, ic_inst}),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );
  assign fetch_e_ = !issue;
  assign fetch_pc = pc;
  assign inst_e_  = !pop;
  assign inst_pc  = empty ? '0 : head[ADDR+INST-1:INST];
  assign inst     = empty ? '0 : head[INST-1:0];
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_resp_has_req: assert property (@(posedge clk) disable iff (reset) !(resp && outstanding == '0));
  a_discard_bound: assert property (@(posedge clk) disable iff (reset) discard <= outstanding);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with an in-order i-cache model and a queue-level reference of the fetch stream
module tb_fetch_unit;
  logic clk = 0, reset;
  logic fetch_e_, ic_e_, inst_e_, dec_jump_, dec_branch_, stall, flush_;
  logic [31:0] fetch_pc, ic_pc, ic_inst, inst_pc, inst, dec_target, flush_pc;
  typedef struct {logic [31:0] pc; int due; bit stale;} req_t;
  req_t pend[$];
  logic [31:0] mq[$];
  logic [31:0] m_pc, e_fpc, e_ipc, e_inst, e_tgt;
  logic e_fe, e_ie, e_redir, will_resp;
  int cyc, lat, checks, errors;

  fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_e_(fetch_e_), .fetch_pc(fetch_pc),
    .ic_e_(ic_e_), .ic_pc(ic_pc), .ic_inst(ic_inst),
    .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst),
    .dec_jump_(dec_jump_), .dec_branch_(dec_branch_), .dec_target(dec_target),
    .stall(stall), .flush_(flush_), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] pc);
    return ~pc ^ 32'h1234_5678;
  endfunction

  // drive one cycle's inputs and derive the expected outputs from the reference queues
  task automatic drive(input bit st, input bit fl, input bit jp, input bit br,
                       input logic [31:0] tgt, input logic [31:0] fpc);
    stall = st; flush_ = !fl; dec_jump_ = !jp; dec_branch_ = !br;
    dec_target = tgt; flush_pc = fpc;
    will_resp = pend.size() > 0 && pend[0].due <= cyc;
    ic_e_ = !will_resp;
    ic_pc = will_resp ? pend[0].pc : 32'h0;
    ic_inst = will_resp ? f(pend[0].pc) : 32'h0;
    e_redir = fl || jp || br;
    e_tgt = fl ? fpc : tgt;
    e_fe = !(!e_redir && pend.size() < 4 && mq.size() + pend.size() < 4);
    e_fpc = m_pc;
    e_ie = !(mq.size() > 0 && !st && !e_redir);
    e_ipc = mq.size() > 0 ? mq[0] : 32'h0;
    e_inst = mq.size() > 0 ? f(mq[0]) : 32'h0;
    #1;
  endtask

  task automatic advance();
    req_t r;
    if (will_resp) r = pend.pop_front();
    if (!e_ie) void'(mq.pop_front());
    if (will_resp && !r.stale && !e_redir) mq.push_back(r.pc);
    if (e_redir) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1;
      m_pc = e_tgt;
    end
    if (!fetch_e_) pend.push_back('{fetch_pc, cyc + lat, 1'b0});
    if (!e_fe) m_pc = m_pc + 32'd4;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic hold_reset();
    reset = 1; stall = 0; flush_ = 1; dec_jump_ = 1; dec_branch_ = 1; ic_e_ = 1;
    pend.delete(); mq.delete(); m_pc = 32'h0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    hold_reset();
    checks += 5;
    if (fetch_e_ !== 1'b1) begin errors++; $display("FAIL reset fetch_e_ got %b want 1", fetch_e_); end
    if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset fetch_pc got %h want 0", fetch_pc); end
    if (inst_e_ !== 1'b1) begin errors++; $display("FAIL reset inst_e_ got %b want 1", inst_e_); end
    if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset inst_pc got %h want 0", inst_pc); end
    if (inst !== 32'h0) begin errors++; $display("FAIL reset inst got %h want 0", inst); end
    hold_reset();
    reset = 0;
  endtask

  task automatic test_sequential();
    lat = 1;
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL seq cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      if (k <= 3) begin
        checks++;
        if (fetch_e_ !== 1'b0 || fetch_pc !== 32'((k - 1) * 4)) begin
          errors++; $display("FAIL seq_issue cyc=%0d got fe=%b fpc=%h want fe=0 fpc=%h", k, fetch_e_, fetch_pc, (k - 1) * 4);
        end
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (inst_e_ !== (k == 2) || (k == 3 && inst_pc !== 32'h0)) begin
          errors++; $display("FAIL seq_first_inst cyc=%0d got ie=%b ipc=%h want ie=%b ipc=0", k, inst_e_, inst_pc, k == 2);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    lat = 2;
    for (int k = 1; k <= 25; k++) begin
      drive(k <= 10, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL stall cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      if (k == 10) begin
        checks++;
        if (fetch_e_ !== 1'b1 || inst_e_ !== 1'b1) begin
          errors++; $display("FAIL stall_full got fe=%b ie=%b want fe=1 ie=1", fetch_e_, inst_e_);
        end
      end
      advance();
    end
  endtask

  task automatic test_jump();
    int n = 0;
    bit seen = 0;
    lat = 3;
    while (pend.size() != 3 && n < 30) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL jump_pre got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      advance();
      n++;
    end
    checks++;
    if (n == 30) begin errors++; $display("FAIL jump_setup outstanding got %0d want 3", pend.size()); end
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(0, 0, k == 0, 0, 32'h100, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL jump cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      if (k > 0 && inst_e_ === 1'b0) begin
        seen = 1;
        checks++;
        if (inst_pc !== 32'h100) begin errors++; $display("FAIL jump_target got %h want 00000100", inst_pc); end
      end
      advance();
    end
    if (!seen) begin checks++; errors++; $display("FAIL jump_timeout got no instruction want 00000100"); end
  endtask

  task automatic test_flush_priority();
    for (int k = 0; k < 2; k++) begin
      drive(0, k == 0, 0, k == 0, 32'h300, 32'h200);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL prio cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      if (k == 1) begin
        checks++;
        if (fetch_pc !== 32'h200 || inst_e_ !== 1'b1) begin
          errors++; $display("FAIL prio_target got fpc=%h ie=%b want fpc=00000200 ie=1", fetch_pc, inst_e_);
        end
      end
      advance();
    end
  endtask

  task automatic test_resp_redirect();
    int n = 0;
    bit seen = 0;
    lat = 2;
    while (!(pend.size() == 2 && pend[0].due <= cyc) && n < 30) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL rr_pre got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      advance();
      n++;
    end
    checks++;
    if (n == 30) begin errors++; $display("FAIL rr_setup outstanding got %0d want 2 with response", pend.size()); end
    for (int k = 0; k < 20 && !seen; k++) begin
      drive(0, 0, k == 0, 0, 32'h400, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL rr cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      if (k > 0 && inst_e_ === 1'b0) begin
        seen = 1;
        checks++;
        if (inst_pc !== 32'h400) begin errors++; $display("FAIL rr_target got %h want 00000400", inst_pc); end
      end
      advance();
    end
    if (!seen) begin checks++; errors++; $display("FAIL rr_timeout got no instruction want 00000400"); end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    lat = 3;
    while (pend.size() != 2 && n < 30) begin
      drive(0, n == 0, 0, 0, 32'h0, 32'h800);
      advance();
      n++;
    end
    checks++;
    if (n == 30) begin errors++; $display("FAIL mid_setup outstanding got %0d want 2", pend.size()); end
    hold_reset();
    checks++;
    if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {1'b1, 32'h0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=1 fpc=0 ie=1 ipc=0 inst=0",
               fetch_e_, fetch_pc, inst_e_, inst_pc, inst);
    end
    reset = 0;
    lat = 1;
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL mid cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      if (k == 1) begin
        checks++;
        if (fetch_e_ !== 1'b0 || fetch_pc !== 32'h0) begin
          errors++; $display("FAIL mid_restart got fe=%b fpc=%h want fe=0 fpc=0", fetch_e_, fetch_pc);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) lat = $urandom_range(1, 4);
      drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 5, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
      checks++;
      if ({fetch_e_, fetch_pc, inst_e_, inst_pc, inst} !== {e_fe, e_fpc, e_ie, e_ipc, e_inst}) begin
        errors++;
        $display("FAIL rand cyc=%0d got fe=%b fpc=%h ie=%b ipc=%h inst=%h want fe=%b fpc=%h ie=%b ipc=%h inst=%h",
                 k, fetch_e_, fetch_pc, inst_e_, inst_pc, inst, e_fe, e_fpc, e_ie, e_ipc, e_inst);
      end
      advance();
    end
  endtask

  initial begin
    reset = 1; stall = 0; flush_ = 1; dec_jump_ = 1; dec_branch_ = 1;
    dec_target = 0; flush_pc = 0; ic_e_ = 1; ic_pc = 0; ic_inst = 0;
    checks = 0; errors = 0; cyc = 0; lat = 1; m_pc = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_flush_priority();
    test_resp_redirect();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
